// File: rtl/ysyx_24100006_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100006_ifu_pkg
// Brief    : Shared types and constants for the instruction fetch unit.
// Revision : 1.0
// ============================================================================
package ysyx_24100006_ifu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0] PC_STEP_DEFAULT  = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifuState_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_24100006_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100006_perf_cnt
// Brief    : Free-running wrap-around event counter with enable and sync reset.
// Revision : 1.0
// ============================================================================
module ysyx_24100006_perf_cnt
    import ysyx_24100006_ifu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ysyx_24100006_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100006_ifu
// Brief    : Instruction fetch unit; one outstanding imem request, registered
//            instruction handoff to ID, redirect support.
//            Optional counters enabled by YSYX_24100006_IFU_PERF_EN.
// Revision : 1.0
// ============================================================================
module ysyx_24100006_ifu
    import ysyx_24100006_ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
`ifdef YSYX_24100006_IFU_PERF_EN
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_stall_cnt,
`endif
    output logic            if_fault
);

    ifuState_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_instPc;
    logic            r_drop;
    logic            r_valid;
    logic            r_fault;

    logic            w_reqFire;
    logic            w_ifFire;

    assign imem_req_valid = (r_state == S_REQ) && !reset;
    assign imem_req_addr  = r_pc;
    assign w_reqFire      = imem_req_valid && imem_req_ready;
    assign w_ifFire       = r_valid && if_ready;

    assign if_valid = r_valid;
    assign if_inst  = r_inst;
    assign if_pc    = r_instPc;
    assign if_fault = r_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            // A request left in flight by the reset must not be mistaken for ours.
            r_drop   <= (r_state == S_WAIT);
            r_valid  <= 1'b0;
            r_inst   <= '0;
            r_instPc <= RESET_PC;
            r_fault  <= 1'b0;
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end
                    if (w_reqFire) begin
                        r_state <= S_WAIT;
                        if (redirect_valid) begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                        if (imem_resp_valid) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_drop <= 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_inst   <= imem_resp_data;
                            r_instPc <= r_pc;
                            r_fault  <= imem_resp_err;
                            r_valid  <= 1'b1;
                            r_state  <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // A redirect wins over the handshake: ID flushes on the same redirect.
                    if (redirect_valid) begin
                        r_valid <= 1'b0;
                        r_pc    <= redirect_pc;
                        r_state <= S_REQ;
                    end else if (w_ifFire) begin
                        r_valid <= 1'b0;
                        r_pc    <= r_pc + PC_STEP;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

`ifdef YSYX_24100006_IFU_PERF_EN
    logic w_stallEn;

    assign w_stallEn = (r_state == S_WAIT) || ((r_state == S_HOLD) && !if_ready);

    ysyx_24100006_perf_cnt #(
        .WIDTH (XLEN)
    ) u_fetchCnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_ifFire),
        .count (perf_fetch_cnt)
    );

    ysyx_24100006_perf_cnt #(
        .WIDTH (XLEN)
    ) u_stallCnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_stallEn),
        .count (perf_stall_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100006_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24100006_ifu
// Brief    : Self-checking bench: memory/ID environment plus reference model.
// Revision : 1.0
// ============================================================================
module tb_ysyx_24100006_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_fault;
`ifdef YSYX_24100006_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_24100006_ifu dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_inst         (if_inst),
        .if_pc           (if_pc),
`ifdef YSYX_24100006_IFU_PERF_EN
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt),
`endif
        .if_fault        (if_fault)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Environment controls
    bit          rstIn, rdV, idRdy, dataOvr;
    logic [31:0] rdPc, dataOvrVal;
    int          readyPct, fixedLat;

    // Memory environment: one outstanding request
    bit          memPending;
    int          memCnt;
    logic [31:0] memAddr;

    // Observations of the last cycle
    bit          lastFire, lastHs, lastHsFault, lastIfValid, lastReqValid;
    logic [31:0] lastFireAddr, lastHsPc, lastIfInst, lastIfPc;

    // Reference model: phase 0 = requesting, 1 = awaiting word, 2 = offering to ID
    int          mPhase;
    bit          mDrop, mValid, mFault;
    logic [31:0] mPc, mInst, mIfPc, mFetch, mStall;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    function automatic logic memErr(input logic [31:0] a);
        return (a == 32'h8000_0010) || (a[9:2] == 8'hA7);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelStep(input bit reqReady, input bit respV);
        if (rstIn) begin
            mDrop  = (mPhase == 1);
            mPhase = 0;
            mPc    = RST_PC;
            mValid = 1'b0;
            mInst  = 32'h0;
            mIfPc  = RST_PC;
            mFault = 1'b0;
            mFetch = 32'h0;
            mStall = 32'h0;
            return;
        end
        if (mValid && idRdy) mFetch = mFetch + 32'd1;
        if (mPhase == 1 || (mPhase == 2 && !idRdy)) mStall = mStall + 32'd1;
        case (mPhase)
            0: begin
                if (rdV) mPc = rdPc;
                if (reqReady) begin
                    mPhase = 1;
                    if (rdV) mDrop = 1'b1;
                end
            end
            1: begin
                if (rdV) begin
                    mPc = rdPc;
                    if (respV) begin
                        mDrop  = 1'b0;
                        mPhase = 0;
                    end else begin
                        mDrop = 1'b1;
                    end
                end else if (respV) begin
                    if (mDrop) begin
                        mDrop  = 1'b0;
                        mPhase = 0;
                    end else begin
                        mInst  = memWord(mPc);
                        mIfPc  = mPc;
                        mFault = memErr(mPc);
                        mValid = 1'b1;
                        mPhase = 2;
                    end
                end
            end
            default: begin
                if (rdV) begin
                    mValid = 1'b0;
                    mPc    = rdPc;
                    mPhase = 0;
                end else if (idRdy) begin
                    mValid = 1'b0;
                    mPc    = mPc + 32'd4;
                    mPhase = 0;
                end
            end
        endcase
    endtask

    // One clock: drive inputs, compare outputs with the model, advance model and memory.
    task automatic cycle();
        bit respV;
        bit fire;
        @(negedge clk);
        reset          = rstIn;
        redirect_valid = rdV;
        redirect_pc    = rdPc;
        if_ready       = idRdy;
        respV          = memPending && (memCnt == 0);
        imem_resp_valid = respV;
        imem_resp_data  = respV ? (dataOvr ? dataOvrVal : memWord(memAddr)) : 32'h0;
        imem_resp_err   = respV && memErr(memAddr);
        imem_req_ready  = !memPending && ($urandom_range(99) < readyPct);
        #1;
        checkBit("req_valid", imem_req_valid, (mPhase == 0) && !rstIn);
        check("req_addr", imem_req_addr, mPc);
        checkBit("if_valid", if_valid, mValid);
        check("if_inst", if_inst, mInst);
        check("if_pc", if_pc, mIfPc);
        checkBit("if_fault", if_fault, mFault);
`ifdef YSYX_24100006_IFU_PERF_EN
        check("perf_fetch", perf_fetch_cnt, mFetch);
        check("perf_stall", perf_stall_cnt, mStall);
`endif
        fire         = imem_req_valid && imem_req_ready;
        lastFire     = fire;
        lastFireAddr = imem_req_addr;
        lastHs       = if_valid && if_ready;
        lastHsPc     = if_pc;
        lastHsFault  = if_fault;
        lastIfValid  = if_valid;
        lastIfInst   = if_inst;
        lastIfPc     = if_pc;
        lastReqValid = imem_req_valid;
        modelStep(imem_req_ready, respV);
        if (respV) memPending = 1'b0;
        if (fire) begin
            memPending = 1'b1;
            memAddr    = imem_req_addr;
            memCnt     = (fixedLat > 0) ? fixedLat - 1 : int'($urandom_range(2, 0));
        end else if (memPending) begin
            memCnt--;
        end
        rdV = 1'b0;
        cyc++;
        @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          hsCyc [3];
        logic [31:0] hsPc  [3];
        int          reqs;
        int          fires;
        logic [31:0] heldPc;
        bit          ok;
        bit          sawBeef;

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        imem_resp_err = 1'b0; if_ready = 1'b0;
        rstIn = 1'b1; rdV = 1'b0; rdPc = 32'h0; idRdy = 1'b1; dataOvr = 1'b0; dataOvrVal = 32'h0;
        readyPct = 100; fixedLat = 1;
        memPending = 1'b0; memCnt = 0; memAddr = 32'h0;
        mPhase = 0; mDrop = 1'b0; mValid = 1'b0; mFault = 1'b0;
        mPc = RST_PC; mInst = 32'h0; mIfPc = RST_PC; mFetch = 32'h0; mStall = 32'h0;
        for (int i = 0; i < 3; i++) begin hsCyc[i] = 0; hsPc[i] = 32'h0; end

        // Reset state
        repeat (3) cycle();
        #1;
        checkBit("rst_req_valid", imem_req_valid, 1'b0);
        checkBit("rst_if_valid", if_valid, 1'b0);
        check("rst_if_pc", if_pc, 32'h8000_0000);
        check("rst_if_inst", if_inst, 32'h0);
        checkBit("rst_if_fault", if_fault, 1'b0);

        // Sequential fetch, ideal memory and ID
        rstIn = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            cycle();
            if (lastHs) begin hsPc[n] = lastHsPc; hsCyc[n] = cyc; n++; end
        end
        checkInt("seq_count", n, 3);
        check("seq_pc0", hsPc[0], 32'h8000_0000);
        check("seq_pc1", hsPc[1], 32'h8000_0004);
        check("seq_pc2", hsPc[2], 32'h8000_0008);
        checkInt("seq_gap1", hsCyc[1] - hsCyc[0], 3);
        checkInt("seq_gap2", hsCyc[2] - hsCyc[1], 3);

        // ID stalls five cycles while an instruction is held
        idRdy = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (lastIfValid) begin ok = 1'b1; break; end
        end
        checkBit("hold_reached", ok, 1'b1);
        heldPc = lastIfPc;
        reqs = 0;
        repeat (4) begin
            cycle();
            if (lastReqValid) reqs++;
        end
        checkInt("hold_reqs", reqs, 0);
        check("hold_pc", heldPc, 32'h8000_000C);
        idRdy = 1'b1;
        cycle();
        checkBit("hold_hs", lastHs, 1'b1);
        cycle();
        checkBit("hold_fire", lastFire, 1'b1);
        check("hold_next_addr", lastFireAddr, 32'h8000_0010);

        // Access fault at 0x80000010
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (lastHs) begin ok = 1'b1; break; end
        end
        checkBit("fault_hs", ok, 1'b1);
        check("fault_pc", lastHsPc, 32'h8000_0010);
        checkBit("fault_flag", lastHsFault, 1'b1);
        cycle();
        check("fault_next_addr", lastFireAddr, 32'h8000_0014);

        // Redirect while awaiting a word; stale word 0xDEADBEEF must vanish
        fixedLat = 3;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (lastFire) begin ok = 1'b1; break; end
        end
        checkBit("wredir_fire", ok, 1'b1);
        rdV = 1'b1; rdPc = 32'h8000_1000;
        dataOvr = 1'b1; dataOvrVal = 32'hDEAD_BEEF;
        sawBeef = 1'b0; ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (lastIfValid && lastIfInst == 32'hDEAD_BEEF) sawBeef = 1'b1;
            if (lastFire) begin ok = 1'b1; break; end
        end
        dataOvr = 1'b0;
        checkBit("wredir_refire", ok, 1'b1);
        check("wredir_addr", lastFireAddr, 32'h8000_1000);
        checkBit("wredir_no_beef", sawBeef, 1'b0);

        // Redirect while holding with ID not ready
        fixedLat = 1;
        idRdy = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (lastIfValid) begin ok = 1'b1; break; end
        end
        checkBit("hredir_hold", ok, 1'b1);
        rdV = 1'b1; rdPc = 32'h8000_0100;
        cycle();
        cycle();
        checkBit("hredir_valid", lastIfValid, 1'b0);
        checkBit("hredir_fire", lastFire, 1'b1);
        check("hredir_addr", lastFireAddr, 32'h8000_0100);

        // PC wrap-around
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (lastIfValid) begin ok = 1'b1; break; end
        end
        checkBit("wrap_hold", ok, 1'b1);
        rdV = 1'b1; rdPc = 32'hFFFF_FFFC;
        cycle();
        idRdy = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (lastHs) begin ok = 1'b1; break; end
        end
        checkBit("wrap_hs", ok, 1'b1);
        check("wrap_pc", lastHsPc, 32'hFFFF_FFFC);
        cycle();
        check("wrap_addr", lastFireAddr, 32'h0000_0000);

        // Reset while a response is in flight: the next response is discarded
        fixedLat = 3;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (lastFire) begin ok = 1'b1; break; end
        end
        checkBit("mrst_fire", ok, 1'b1);
        rstIn = 1'b1;
        cycle();
        rstIn = 1'b0;
        fires = 0; ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (lastFire && lastFireAddr == RST_PC) fires++;
            if (lastHs) begin ok = 1'b1; break; end
        end
        checkBit("mrst_hs", ok, 1'b1);
        check("mrst_pc", lastHsPc, 32'h8000_0000);
        checkInt("mrst_fires", fires, 2);

`ifdef YSYX_24100006_IFU_PERF_EN
        // Ten fetches with two-cycle memory latency
        rstIn = 1'b1;
        repeat (2) cycle();
        rstIn = 1'b0;
        fixedLat = 2;
        n = 0;
        for (int i = 0; i < 100 && n < 10; i++) begin
            cycle();
            if (lastHs) n++;
        end
        #1;
        check("perf_fetch10", perf_fetch_cnt, 32'd10);
        check("perf_stall20", perf_stall_cnt, 32'd20);
`endif

        // Randomized traffic
        fixedLat = 0;
        readyPct = 70;
        for (int i = 0; i < 3000; i++) begin
            idRdy = ($urandom_range(99) < 70);
            rdV   = ($urandom_range(99) < 4);
            rdPc  = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC
                                              : (RST_PC | (32'($urandom_range(255)) << 2));
            rstIn = ($urandom_range(999) < 3);
            cycle();
        end
        rstIn = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
